// File: rtl/pp_gen_stage_if.sv
// Valid/ready bus between the operand source, the partial-product stage and the reduction tree.
interface pp_gen_stage_if #(
  parameter int W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [W*W-1:0]   pp;
  logic [2*W-1:0]   pp_corr;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, pp, pp_corr
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, pp, pp_corr
  );
endinterface

// File: rtl/pp_gen_stage.sv
// Two-stage valid/ready partial-product generator feeding a multiplier reduction tree.
// Define PP_GEN_SIGNED_EN for Baugh-Wooley signed rows plus the matching correction constant.
module pp_gen_stage #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pp_gen_stage_if.slave bus,
  output logic [15:0]   txn_cnt
);

`ifdef PP_GEN_SIGNED_EN
  localparam logic [2*W-1:0] PP_CORR = {1'b1, {(W-2){1'b0}}, 1'b1, {W{1'b0}}};
`else
  localparam logic [2*W-1:0] PP_CORR = '0;
`endif

  logic             v1;
  logic             v2;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W*W-1:0]   pp_q;
  logic [W*W-1:0]   pp_d;
  logic [2*W-1:0]   corr_q;
  logic             s2_load;
  logic             in_hs;
  logic             out_hs;

  // S2 takes S1 whenever it is empty or draining this cycle, which also frees S1.
  assign s2_load = v1 && (!v2 || bus.out_ready);
  assign out_hs  = v2 && bus.out_ready;
  assign bus.in_ready  = !v1 || s2_load;
  assign in_hs   = bus.in_valid && bus.in_ready;

  assign bus.out_valid = v2;
  assign bus.pp        = pp_q;
  assign bus.pp_corr   = corr_q;

  // Rows are left unshifted; the reduction tree applies the i-bit weight of row i.
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        pp_d[i*W+j] = a_q[j] & b_q[i];
`ifdef PP_GEN_SIGNED_EN
        if ((i == W-1) != (j == W-1)) begin
          pp_d[i*W+j] = ~(a_q[j] & b_q[i]);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else if (in_hs) begin
      v1  <= 1'b1;
      a_q <= bus.a;
      b_q <= bus.b;
    end else if (s2_load) begin
      v1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      pp_q   <= '0;
      corr_q <= '0;
    end else if (s2_load) begin
      v2     <= 1'b1;
      pp_q   <= pp_d;
      corr_q <= PP_CORR;
    end else if (out_hs) begin
      v2     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (out_hs) begin
      txn_cnt <= txn_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pp_gen_stage.sv
// Directed and randomized self-checking bench for pp_gen_stage (W=8).
// Works in both builds; PP_GEN_SIGNED_EN switches the expected values to signed mode.
module tb_pp_gen_stage;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] txn_cnt;
  int          errors = 0;
  int          checks = 0;

  pp_gen_stage_if #(.W(W)) bus ();

  pp_gen_stage #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .txn_cnt (txn_cnt)
  );

  always #5 clk = ~clk;

  // Reference product: what the shifted rows plus correction must add up to.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef PP_GEN_SIGNED_EN
    logic signed [2*W-1:0] sx;
    logic signed [2*W-1:0] sy;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    return sx * sy;
`else
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
  endfunction

  function automatic logic [2*W-1:0] pp_sum(input logic [W*W-1:0] p, input logic [2*W-1:0] c);
    logic [2*W-1:0] s;
    s = c;
    for (int i = 0; i < W; i++) s = s + ({{W{1'b0}}, p[i*W +: W]} << i);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 8'h5A;
    bus.b = 8'hC3;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    checks++;
    if (bus.pp !== 64'h0) begin errors++; $display("[TB] FAIL reset_pp: got %h expected 0", bus.pp); end
    checks++;
    if (bus.pp_corr !== 16'h0) begin errors++; $display("[TB] FAIL reset_pp_corr: got %h expected 0", bus.pp_corr); end
    checks++;
    if (txn_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_txn_cnt: got %h expected 0", txn_cnt); end
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_output: got %0b expected 0", bus.out_valid); end
  endtask

`ifndef PP_GEN_SIGNED_EN
  task automatic test_unsigned();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'h01;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL uns_in_ready: got %0b expected 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL uns_latency_early: got %0b expected 0", bus.out_valid); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL uns_out_valid: got %0b expected 1", bus.out_valid); end
    checks++;
    if (bus.pp !== 64'h00000000000000FF) begin errors++; $display("[TB] FAIL uns_pp_ff_01: got %h expected 00000000000000ff", bus.pp); end
    checks++;
    if (bus.pp_corr !== 16'h0) begin errors++; $display("[TB] FAIL uns_pp_corr: got %h expected 0", bus.pp_corr); end
    tick();
    checks++;
    if (txn_cnt !== 16'd1) begin errors++; $display("[TB] FAIL uns_txn_cnt1: got %0d expected 1", txn_cnt); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL uns_out_clear: got %0b expected 0", bus.out_valid); end
    bus.in_valid = 1'b1;
    bus.a = 8'hA5;
    bus.b = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.pp !== 64'h0000A5A5A5A50000) begin errors++; $display("[TB] FAIL uns_pp_a5_3c: got %h expected 0000a5a5a5a50000", bus.pp); end
    tick();
    checks++;
    if (txn_cnt !== 16'd2) begin errors++; $display("[TB] FAIL uns_txn_cnt2: got %0d expected 2", txn_cnt); end
  endtask
`else
  task automatic test_signed();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 8'h80;
    bus.b = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sgn_latency_early: got %0b expected 0", bus.out_valid); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sgn_out_valid: got %0b expected 1", bus.out_valid); end
    checks++;
    if (bus.pp !== 64'hFF00000000000000) begin errors++; $display("[TB] FAIL sgn_pp_80_ff: got %h expected ff00000000000000", bus.pp); end
    checks++;
    if (bus.pp_corr !== 16'h8100) begin errors++; $display("[TB] FAIL sgn_pp_corr: got %h expected 8100", bus.pp_corr); end
    checks++;
    if (pp_sum(bus.pp, bus.pp_corr) !== 16'h0080) begin errors++; $display("[TB] FAIL sgn_sum: got %h expected 0080", pp_sum(bus.pp, bus.pp_corr)); end
    tick();
    checks++;
    if (txn_cnt !== 16'd1) begin errors++; $display("[TB] FAIL sgn_txn_cnt1: got %0d expected 1", txn_cnt); end
  endtask
`endif

  task automatic test_back_pressure();
    logic [W-1:0] va [4] = '{8'h11, 8'h9C, 8'h7F, 8'hE3};
    logic [W-1:0] vb [4] = '{8'h01, 8'h05, 8'hFF, 8'h80};
    int k = 0;
    int r = 0;
    int cyc = 0;
    do_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.a = va[k];
      bus.b = vb[k];
      #1;
      if (c >= 2) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_c%0d: got %0b expected 0", c, bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid_c%0d: got %0b expected 1", c, bus.out_valid); end
        checks++;
        if (pp_sum(bus.pp, bus.pp_corr) !== ref_prod(va[0], vb[0]))
          begin errors++; $display("[TB] FAIL bp_hold_c%0d: got %h expected %h", c, pp_sum(bus.pp, bus.pp_corr), ref_prod(va[0], vb[0])); end
      end
      if (bus.in_ready) k++;
      tick();
    end
    checks++;
    if (k !== 2) begin errors++; $display("[TB] FAIL bp_accepts: got %0d expected 2", k); end
    bus.out_ready = 1'b1;
    while (r < 4 && cyc < 20) begin
      bus.in_valid = (k < 4);
      bus.a = va[k % 4];
      bus.b = vb[k % 4];
      #1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (pp_sum(bus.pp, bus.pp_corr) !== ref_prod(va[r], vb[r]))
          begin errors++; $display("[TB] FAIL bp_result%0d: got %h expected %h", r, pp_sum(bus.pp, bus.pp_corr), ref_prod(va[r], vb[r])); end
        r++;
      end
      if (bus.in_valid && bus.in_ready) k++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (r !== 4) begin errors++; $display("[TB] FAIL bp_drain: got %0d results expected 4", r); end
    checks++;
    if (txn_cnt !== 16'd4) begin errors++; $display("[TB] FAIL bp_txn_cnt: got %0d expected 4", txn_cnt); end
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 8'h12;
    bus.b = 8'h34;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async: got %0b expected 0", bus.out_valid); end
    checks++;
    if (bus.pp !== 64'h0) begin errors++; $display("[TB] FAIL midrst_pp: got %h expected 0", bus.pp); end
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_emitted: got %0b expected 0", seen); end
    checks++;
    if (txn_cnt !== 16'd0) begin errors++; $display("[TB] FAIL midrst_txn_cnt: got %0d expected 0", txn_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [6] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'h5A};
    logic [W-1:0] vb [6] = '{8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'hA5};
    int k = 0;
    int r = 0;
    int first = -1;
    int last = -1;
    bit seen = 1'b0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = (k < 6);
      bus.a = va[k % 6];
      bus.b = vb[k % 6];
      #1;
      if (bus.in_valid) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready_c%0d: got %0b expected 1", c, bus.in_ready); end
        if (bus.in_ready) k++;
      end
      if (bus.out_valid && r < 6) begin
        if (first < 0) first = c;
        last = c;
        checks++;
        if (pp_sum(bus.pp, bus.pp_corr) !== ref_prod(va[r], vb[r]))
          begin errors++; $display("[TB] FAIL b2b_result%0d: got %h expected %h", r, pp_sum(bus.pp, bus.pp_corr), ref_prod(va[r], vb[r])); end
        r++;
      end
      tick();
    end
    checks++;
    if (first !== 2) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 2", first); end
    checks++;
    if (last !== 7) begin errors++; $display("[TB] FAIL b2b_throughput_last: got %0d expected 7", last); end
    checks++;
    if (txn_cnt !== 16'd6) begin errors++; $display("[TB] FAIL b2b_txn_cnt: got %0d expected 6", txn_cnt); end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.a = 8'h3C + 8'(c);
      bus.b = 8'hC3 - 8'(c);
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_ignored: got %0b expected 0", seen); end
    checks++;
    if (txn_cnt !== 16'd6) begin errors++; $display("[TB] FAIL b2b_idle_txn_cnt: got %0d expected 6", txn_cnt); end
  endtask

  task automatic test_random();
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] e;
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    do_reset();
    while (rcv < 1000 && cyc < 10000) begin
      bus.in_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_prod(bus.a, bus.b));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rnd_duplicate: got extra result %h expected none", pp_sum(bus.pp, bus.pp_corr));
        end else begin
          e = exp_q.pop_front();
          if (pp_sum(bus.pp, bus.pp_corr) !== e)
            begin errors++; $display("[TB] FAIL rnd_result%0d: got %h expected %h", rcv, pp_sum(bus.pp, bus.pp_corr), e); end
        end
        rcv++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (rcv !== 1000) begin errors++; $display("[TB] FAIL rnd_count: got %0d expected 1000", rcv); end
    checks++;
    if (txn_cnt !== 16'd1000) begin errors++; $display("[TB] FAIL rnd_txn_cnt: got %0d expected 1000", txn_cnt); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int rcv = 0;
    int cyc = 0;
    do_reset();
    bus.out_ready = 1'b1;
    bus.a = 8'h03;
    bus.b = 8'h05;
    while (rcv < 65535 && cyc < 66000) begin
      bus.in_valid = (sent < 65535);
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) rcv++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (txn_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_preload: got %h expected ffff", txn_cnt); end
    cyc = 0;
    while (rcv < 65536 && cyc < 10) begin
      bus.in_valid = (sent < 65536);
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) rcv++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (txn_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_rollover: got %h expected 0000", txn_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
`ifndef PP_GEN_SIGNED_EN
    test_unsigned();
`else
    test_signed();
`endif
    test_back_pressure();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
